data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Responder end of the datapath's data-memory interface. It accepts word read/write
//   requests (address = aluout, write data = writedata) and returns readdata.
//   Word-addressed RAM with a req/ready handshake and a programmable wait-state count.
//   Flags misaligned and out-of-range accesses instead of corrupting memory.
// PARAMETERS
//   DEPTH_WORDS  1024           number of 32-bit words stored (power of two)
//   BASE_ADDR    32'h10010000   byte address of word 0 (data segment base)
//   WAIT_CYCLES  2              wait states between acceptance and response, 0..15
// PORTS
//   clk     in   1   clock, all state updates on rising edge
//   reset   in   1   asynchronous, active-low reset
//   req     in   1   initiator requests an access; held until ready seen
//   we      in   1   1 = write, 0 = read; sampled with req
//   addr    in   32  byte address; sampled with req
//   wdata   in   32  write data; sampled with req
//   rdata   out  32  read data; valid while ready=1, held until next response
//   ready   out  1   single-cycle response strobe
//   error   out  1   response is an error; valid while ready=1
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, ready=0, error=0, rdata=0, wait counter=0.
//     RAM contents are not cleared. A transaction in flight is dropped; its write is
//     not performed.
//   - FSM states: IDLE, WAIT, RESP.
//   - IDLE:
//     - If req=1 at an edge: latch we/addr/wdata and compute the error flag.
//     - Next state is WAIT with counter=WAIT_CYCLES-1, or RESP if WAIT_CYCLES=0.
//     - If req=0: stay in IDLE.
//   - WAIT: counter decrements each edge. When the counter is 0, the next edge enters RESP.
//   - Commit edge (entry into RESP):
//     - Read: rdata <= mem[idx].
//     - Write: mem[idx] <= wdata; rdata keeps its old value.
//     - Error: no RAM access; rdata <= 0.
//   - RESP: ready=1 and error valid for exactly one cycle, then IDLE unconditionally.
//     req is ignored in RESP.
//   - Latency: ready is high in cycle WAIT_CYCLES+1 after the accepting edge
//     (WAIT_CYCLES=2 gives 3 cycles).
//   - Back-to-back: if the initiator keeps req=1 after ready, IDLE accepts it as a
//     new request. Minimum spacing is WAIT_CYCLES+2 cycles per access.
//   - req dropped during WAIT: the latched transaction still completes and responds.
//     Inputs changing after acceptance have no effect.
//   - Index: idx = (addr - BASE_ADDR) >> 2, computed with 32-bit unsigned subtraction
//     (wraps below base).
//   - Error conditions:
//     - addr[1:0] != 0, or
//     - idx >= DEPTH_WORDS (includes addresses below BASE_ADDR via wrap).
//   - ready=0 implies error=0. rdata is stable outside commit edges.
// TESTING
//   1 Reset: hold reset=0 for 2 cycles, pulse req=1 -> ready/error/rdata stay 0,
//     no state change.
//   2 Write then read: write addr=0x10010004 wdata=0xDEADBEEF, then read same addr
//     -> each ready exactly 3 cycles after accept; read rdata=0xDEADBEEF, error=0.
//   3 Boundary: write 0x1001_0FFC (idx 1023) -> ok.
//     Write 0x1001_1000 -> error=1, rdata=0.
//     Read 0x1000_FFFC -> error=1. Re-read idx 1023 is unchanged.
//   4 Misaligned: write addr=0x10010006 wdata=0x12345678 -> error=1.
//     Read 0x10010004 still returns 0xDEADBEEF.
//   5 Hold/drop: drop req 1 cycle after accept, toggle addr/wdata -> response with the
//     original addr/data. Then hold req high across ready -> second access accepted in
//     the IDLE cycle, responses 4 cycles apart.
//   6 Reset mid-op: assert reset=0 during WAIT of a write to 0x10010008 -> no ready.
//     After release, reading 0x10010008 returns its previous value.
//     Repeat scenario 2 with WAIT_CYCLES=0 -> ready 1 cycle after accept.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Request/response bundle between a datapath data-memory port and its responder.
interface data_memory_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, error
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data RAM behind a req/ready handshake with a fixed number of wait states.
// Misaligned or out-of-window accesses answer with error and never touch the array.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    data_memory_responder_if.slave bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;

    logic [3:0]       wait_count;
    logic             lat_we;
    logic             lat_err;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      lat_wdata;
    logic [31:0]      rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]      word_off;
    logic             in_err;
    logic [IDX_W-1:0] in_idx;

    logic             commit;
    logic             c_we;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;
    logic [31:0]      c_wdata;

    // Unsigned subtraction makes addresses below the base wrap to huge indices, which fail the range test.
    always_comb begin
        word_off = 30'((bus.addr - BASE_ADDR) >> 2);
        in_err   = (bus.addr[1:0] != 2'b00) || (word_off >= 30'(DEPTH_WORDS));
        in_idx   = word_off[IDX_W-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.req) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (wait_count == 4'd0) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // With zero wait states the commit happens on the accepting edge, so use live inputs.
        commit  = (state_next == RESP) && (state != RESP);
        c_we    = (state == IDLE) ? bus.we    : lat_we;
        c_err   = (state == IDLE) ? in_err    : lat_err;
        c_idx   = (state == IDLE) ? in_idx    : lat_idx;
        c_wdata = (state == IDLE) ? bus.wdata : lat_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_count <= 4'd0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state <= state_next;

            if (state == IDLE && bus.req) begin
                lat_we     <= bus.we;
                lat_err    <= in_err;
                lat_idx    <= in_idx;
                lat_wdata  <= bus.wdata;
                wait_count <= WAIT_LOAD;
            end else if (state == WAIT && wait_count != 4'd0) begin
                wait_count <= wait_count - 4'd1;
            end

            if (commit) begin
                if (c_err)
                    rdata_q <= 32'd0;
                else if (!c_we)
                    rdata_q <= mem[c_idx];
            end
        end
    end

    // The array is not reset; the reset term only blocks a zero-wait commit while reset is held.
    always_ff @(posedge clk) begin
        if (commit && reset && c_we && !c_err)
            mem[c_idx] <= c_wdata;
    end

    assign bus.ready = (state == RESP);
    assign bus.error = (state == RESP) && lat_err;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench for data_memory_responder: a two-wait-state and a zero-wait-state instance
// checked against an array model of the word memory and its response rules.
module tb_data_memory_responder;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int unsigned DEPTH = 1024;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        sel   = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic        cur_ready;
    logic        cur_error;
    logic [31:0] cur_rdata;

    int check_count = 0;
    int fail_count  = 0;

    logic [31:0] ref_mem   [2][DEPTH];
    bit          ref_valid [2][DEPTH];
    logic [31:0] ref_rdata [2];
    bit          ref_known [2];

    data_memory_responder_if bus2();
    data_memory_responder_if bus0();

    assign bus2.req   = sel ? 1'b0 : req;
    assign bus2.we    = we;
    assign bus2.addr  = addr;
    assign bus2.wdata = wdata;
    assign bus0.req   = sel ? req : 1'b0;
    assign bus0.we    = we;
    assign bus0.addr  = addr;
    assign bus0.wdata = wdata;

    assign cur_ready = sel ? bus0.ready : bus2.ready;
    assign cur_error = sel ? bus0.error : bus2.error;
    assign cur_rdata = sel ? bus0.rdata : bus2.rdata;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference rules: error if misaligned or outside the window, reads return the stored word, writes leave rdata alone.
    task automatic refAccess(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                             output logic err, output logic [31:0] rd, output bit known);
        logic [31:0] widx;
        widx = (a - BASE) / 4;
        err  = ((a % 4) != 0) || (widx >= DEPTH);
        if (err) begin
            ref_rdata[d] = 32'd0;
            ref_known[d] = 1'b1;
        end else if (w) begin
            ref_mem[d][widx[9:0]]   = wd;
            ref_valid[d][widx[9:0]] = 1'b1;
        end else begin
            ref_rdata[d] = ref_mem[d][widx[9:0]];
            ref_known[d] = ref_valid[d][widx[9:0]];
        end
        rd    = ref_rdata[d];
        known = ref_known[d];
    endtask

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            ref_rdata[d] = 32'd0;
            ref_known[d] = 1'b1;
        end
    endtask

    task automatic waitReady(input bit drop_early, input logic w, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (cur_ready) begin
                seen = 1'b1;
            end else begin
                checkOutput("error_quiet", 32'(cur_error), 32'd0);
                if (drop_early && n == 1) begin
                    req   = 1'b0;
                    we    = ~w;
                    addr  = $urandom;
                    wdata = $urandom;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] wd, input bit drop_early);
        logic        exp_err;
        logic [31:0] exp_rd;
        bit          known;
        int          n;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = wd;
        refAccess(sel ? 1 : 0, w, a, wd, exp_err, exp_rd, known);
        waitReady(drop_early, w, n);
        req = 1'b0;
        checkOutput("latency", 32'(n), sel ? 32'd1 : 32'd3);
        checkOutput("error", 32'(cur_error), 32'(exp_err));
        if (known) checkOutput("rdata", cur_rdata, exp_rd);
        @(posedge clk);
        #1;
        checkOutput("strobe", 32'(cur_ready), 32'd0);
        if (known) checkOutput("rdata_hold", cur_rdata, exp_rd);
    endtask

    task automatic applyBackToBack(input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                                   input logic w2, input logic [31:0] a2, input logic [31:0] d2);
        logic        exp_err;
        logic [31:0] exp_rd;
        bit          known;
        int          n;
        @(negedge clk);
        req   = 1'b1;
        we    = w1;
        addr  = a1;
        wdata = d1;
        refAccess(sel ? 1 : 0, w1, a1, d1, exp_err, exp_rd, known);
        waitReady(1'b0, w1, n);
        checkOutput("b2b_latency", 32'(n), sel ? 32'd1 : 32'd3);
        checkOutput("b2b_error1", 32'(cur_error), 32'(exp_err));
        if (known) checkOutput("b2b_rdata1", cur_rdata, exp_rd);
        we    = w2;
        addr  = a2;
        wdata = d2;
        refAccess(sel ? 1 : 0, w2, a2, d2, exp_err, exp_rd, known);
        waitReady(1'b0, w2, n);
        req = 1'b0;
        checkOutput("b2b_spacing", 32'(n), sel ? 32'd2 : 32'd4);
        checkOutput("b2b_error2", 32'(cur_error), 32'(exp_err));
        if (known) checkOutput("b2b_rdata2", cur_rdata, exp_rd);
        @(posedge clk);
        #1;
        checkOutput("b2b_strobe", 32'(cur_ready), 32'd0);
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
            1:       a = BASE + 32'd4096 + 32'($urandom_range(0, 255) * 4);
            2:       a = BASE - 32'($urandom_range(1, 64) * 4);
            3:       a = BASE + 32'($urandom_range(1020, 1023) * 4);
            default: a = BASE + 32'($urandom_range(0, 15) * 4);
        endcase
        return a;
    endfunction

    initial begin
        $display("[TB] start");
        resetModel();

        repeat (2) @(posedge clk);
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h10010010;
        wdata = 32'h55AA55AA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_ready", 32'(cur_ready), 32'd0);
            checkOutput("reset_error", 32'(cur_error), 32'd0);
            checkOutput("reset_rdata", cur_rdata, 32'd0);
        end
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(1'b1, 32'h10010004, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 32'h10010004, 32'h0, 1'b0);

        applyStimulus(1'b1, 32'h10010FFC, 32'h0A0B0C0D, 1'b0);
        applyStimulus(1'b1, 32'h10011000, 32'h11111111, 1'b0);
        applyStimulus(1'b0, 32'h1000FFFC, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h10010FFC, 32'h0, 1'b0);

        applyStimulus(1'b1, 32'h10010006, 32'h12345678, 1'b0);
        applyStimulus(1'b0, 32'h10010004, 32'h0, 1'b0);

        applyStimulus(1'b1, 32'h10010014, 32'h600DF00D, 1'b1);
        applyStimulus(1'b0, 32'h10010014, 32'h0, 1'b1);
        applyBackToBack(1'b1, 32'h10010020, 32'h13579BDF, 1'b0, 32'h10010020, 32'h0);

        // Reset lands while the second write is still waiting, so the old word must survive.
        applyStimulus(1'b1, 32'h10010008, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h10010008;
        wdata = 32'h0BADBEEF;
        @(posedge clk);
        #1;
        req   = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("midreset_ready", 32'(cur_ready), 32'd0);
            checkOutput("midreset_rdata", cur_rdata, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        resetModel();
        applyStimulus(1'b0, 32'h10010008, 32'h0, 1'b0);

        repeat (40) applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom, 1'($urandom_range(0, 1)));

        @(negedge clk);
        sel = 1'b1;
        applyStimulus(1'b1, 32'h10010004, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 32'h10010004, 32'h0, 1'b0);
        applyBackToBack(1'b1, 32'h10010FFC, 32'h89ABCDEF, 1'b0, 32'h10010FFC, 32'h0);
        repeat (20) applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom, 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", check_count, fail_count);
        $finish;
    end

endmodule
